// File: rtl/aes_round1.sv
// AES-128 round 1 (AddRoundKey, SubBytes, ShiftRows, MixColumns, AddRoundKey) with on-the-fly
// expansion of round key 1. The result is registered, so the output follows the inputs by one cycle.
module aes_round1 (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] plain_txt,
  input  logic [127:0] subkey0,
  output logic [127:0] round1_out
);

  // Standard AES S-box. Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One state column; row 0 sits in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] m0, m1, m2, m3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {m0, m1, m2, m3};
  endfunction

  logic [127:0] s0;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [31:0]  w0, w1, w2, w3, t;
  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] round1_d;
  logic [127:0] round1_q;

  always_comb begin
    s0 = plain_txt ^ subkey0;
    sb = '0;
    sr = '0;
    mc = '0;
    for (int k = 0; k < 16; k++) begin
      sb[127-8*k -: 8] = sbox(s0[127-8*k -: 8]);
    end
    // Byte 4c+r holds s[r][c]; row r takes its byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    w0 = subkey0[127:96];
    w1 = subkey0[95:64];
    w2 = subkey0[63:32];
    w3 = subkey0[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ 32'h01000000;
    w4 = w0 ^ t;
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;

    round1_d = mc ^ {w4, w5, w6, w7};
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round1_q <= '0;
    end else begin
      round1_q <= round1_d;
    end
  end

  assign round1_out = round1_q;

endmodule

// File: tb/tb_aes_round1.sv
// Bench for aes_round1: reset behaviour, FIPS-197 and zero vectors, back-to-back blocks and a random
// regression against a GF(2^8)-arithmetic reference of AES round 1.
module tb_aes_round1;

  logic         clk;
  logic         reset;
  logic [127:0] plain_txt;
  logic [127:0] subkey0;
  logic [127:0] round1_out;

  int n_cmp;
  int n_err;

  logic [7:0] sbox_m [256];

  aes_round1 dut (
    .clk        (clk),
    .reset      (reset),
    .plain_txt  (plain_txt),
    .subkey0    (subkey0),
    .round1_out (round1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round1(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  st  [16];
    logic [7:0]  sh  [16];
    logic [7:0]  mx  [4][4];
    logic [31:0] w   [8];
    logic [31:0] tmp;
    logic [7:0]  acc;
    logic [127:0] rk;
    logic [127:0] res;
    mx = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
           '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    for (int k = 0; k < 16; k++) st[k] = sbox_m[pt[127-8*k -: 8] ^ key[127-8*k -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sh[4*c+r] = st[4*((c+r)%4)+r];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    tmp = {w[3][23:0], w[3][31:24]};
    tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]} ^ 32'h01000000;
    w[4] = w[0] ^ tmp;
    for (int i = 5; i < 8; i++) w[i] = w[i-1] ^ w[i-4];
    rk = {w[4], w[5], w[6], w[7]};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(mx[r][j], sh[4*c+j]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return res ^ rk;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    plain_txt = {$urandom, $urandom, $urandom, $urandom};
    subkey0 = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (round1_out !== 128'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %h want %h", round1_out, 128'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    plain_txt = 128'h3243f6a8885a308d313198a2e0370734;
    subkey0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(posedge clk);
    #1;
    n_cmp++;
    if (round1_out !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_err++;
      $display("FAIL reset_release_load: got %h want %h", round1_out,
               128'ha49c7ff2689f352b6b5bea43026a5049);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (round1_out !== 128'h0) begin
      n_err++;
      $display("FAIL reset_async_clear: got %h want %h", round1_out, 128'h0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fips();
    @(negedge clk);
    plain_txt = 128'h3243f6a8885a308d313198a2e0370734;
    subkey0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    n_cmp++;
    if (round1_out !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_err++;
      $display("FAIL fips_vector: got %h want %h", round1_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    end
  endtask

  // Every state byte becomes 63 and round key 1 is 62636363 per word, giving 01000000 per word.
  task automatic test_zero();
    @(negedge clk);
    plain_txt = '0;
    subkey0 = '0;
    @(negedge clk);
    n_cmp++;
    if (round1_out !== 128'h01000000010000000100000001000000) begin
      n_err++;
      $display("FAIL zero_vector: got %h want %h", round1_out, 128'h01000000010000000100000001000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp2;
    exp2 = ref_round1(128'hb34d56f78a90c2b1094cd62b0e3445cb, 128'h1ac76d4f3809db6ea555df8213dc6ae9);
    @(negedge clk);
    plain_txt = 128'h3243f6a8885a308d313198a2e0370734;
    subkey0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    plain_txt = 128'hb34d56f78a90c2b1094cd62b0e3445cb;
    subkey0 = 128'h1ac76d4f3809db6ea555df8213dc6ae9;
    n_cmp++;
    if (round1_out !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_err++;
      $display("FAIL b2b_first: got %h want %h", round1_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    end
    @(negedge clk);
    n_cmp++;
    if (round1_out !== exp2) begin
      n_err++;
      $display("FAIL b2b_second: got %h want %h", round1_out, exp2);
    end
  endtask

  task automatic test_random(input int n);
    logic [127:0] exp_prev;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (round1_out !== exp_prev) begin
          n_err++;
          $display("FAIL random[%0d]: got %h want %h", i - 1, round1_out, exp_prev);
        end
      end
      plain_txt = {$urandom, $urandom, $urandom, $urandom};
      subkey0 = {$urandom, $urandom, $urandom, $urandom};
      exp_prev = ref_round1(plain_txt, subkey0);
    end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] exp_v;
    @(negedge clk);
    plain_txt = {$urandom, $urandom, $urandom, $urandom};
    subkey0 = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (round1_out !== 128'h0) begin
      n_err++;
      $display("FAIL midstream_discard: got %h want %h", round1_out, 128'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    plain_txt = {$urandom, $urandom, $urandom, $urandom};
    subkey0 = {$urandom, $urandom, $urandom, $urandom};
    exp_v = ref_round1(plain_txt, subkey0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (round1_out !== exp_v) begin
      n_err++;
      $display("FAIL midstream_resume: got %h want %h", round1_out, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    plain_txt = '0;
    subkey0 = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero();
    test_back_to_back();
    test_random(1000);
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
